// File: rtl/arm_pkg.sv
// -----------------------------------------------------------------------------
// arm_pkg
// Shared constants for the instruction fetch path.
//   WORD_W : instruction / address word width in bits
//   PC_INC : byte increment between sequential instructions
//   NOP    : MOV r0,r0, injected into IF/ID on reset and on a redirect flush
// -----------------------------------------------------------------------------
package arm_pkg;

    localparam int          WORD_W = 32;
    localparam logic [31:0] PC_INC = 32'd4;
    localparam logic [31:0] NOP    = 32'hE1A0_0000;

endpackage

// File: rtl/inst_mem.sv
// -----------------------------------------------------------------------------
// inst_mem
// Read-only instruction memory with a combinational read port. The contents
// come from a packed hex image parameter (word i at bits [32*i +: 32]), so
// they are fixed at elaboration and are unaffected by any reset.
//
// Parameters
//   DEPTH : number of 32-bit words (power of two)
//   INIT  : packed memory image, DEPTH*32 bits
// Ports
//   i_addr  : word index
//   o_rdata : word at i_addr, same cycle
// -----------------------------------------------------------------------------
module inst_mem
    import arm_pkg::*;
#(
    parameter int                        DEPTH = 64,
    parameter logic [DEPTH*WORD_W-1:0]   INIT  = {DEPTH{NOP}}
) (
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    output logic [WORD_W-1:0]        o_rdata
);

    logic [WORD_W-1:0] w_rom [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_rom
        assign w_rom[g] = INIT[g*WORD_W +: WORD_W];
    end

    assign o_rdata = w_rom[i_addr];

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage: PC register, instruction memory lookup and the
// IF/ID pipeline register feeding decode.
//
// Parameters
//   IMEM_DEPTH : instruction memory depth in words (power of two)
//   RESET_PC   : fetch address loaded on reset
//   IMEM_INIT  : packed instruction memory image (word i at [32*i +: 32])
// Ports
//   clk          : clock, rising edge
//   reset        : asynchronous active-high reset
//   freeze       : hazard stall, holds PC register and IF/ID
//   branch_taken : redirect from execute, wins over freeze
//   branch_addr  : redirect target byte address (low two bits dropped)
//   PC           : IF/ID address+4 of the instruction on Instruction
//   Instruction  : IF/ID instruction word
//   valid        : Instruction holds a fetched word, not a reset/flush NOP
//   fetch_count  : number of valid instructions delivered (only when the
//                  FETCH_STATS_EN macro is defined)
// -----------------------------------------------------------------------------
module fetch_unit
    import arm_pkg::*;
#(
    parameter int                             IMEM_DEPTH = 64,
    parameter logic [31:0]                    RESET_PC   = 32'h0000_0000,
    parameter logic [IMEM_DEPTH*WORD_W-1:0]   IMEM_INIT  = {IMEM_DEPTH{NOP}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              freeze,
    input  logic              branch_taken,
    input  logic [WORD_W-1:0] branch_addr,
    output logic [WORD_W-1:0] PC,
    output logic [WORD_W-1:0] Instruction,
    output logic              valid
`ifdef FETCH_STATS_EN
    ,
    output logic [WORD_W-1:0] fetch_count
`endif
);

    localparam int AW = $clog2(IMEM_DEPTH);

    logic [WORD_W-1:0] r_pc_q;
    logic [WORD_W-1:0] r_if_pc;
    logic [WORD_W-1:0] r_if_instr;
    logic              r_if_valid;

    logic [AW-1:0]     w_imem_idx;
    logic [WORD_W-1:0] w_imem_word;
    logic [WORD_W-1:0] w_pc_seq;
    logic [WORD_W-1:0] w_branch_tgt;
    logic              w_load;
    logic              w_unused;

    // Upper address bits alias: only the word index reaches the memory.
    assign w_imem_idx   = r_pc_q[AW+1:2];
    assign w_pc_seq     = r_pc_q + PC_INC;
    assign w_branch_tgt = {branch_addr[WORD_W-1:2], 2'b00};
    assign w_load       = !branch_taken && !freeze;
    assign w_unused     = ^{branch_addr[1:0], r_pc_q[WORD_W-1:AW+2], r_pc_q[1:0]};

    inst_mem #(
        .DEPTH (IMEM_DEPTH),
        .INIT  (IMEM_INIT)
    ) u_imem (
        .i_addr  (w_imem_idx),
        .o_rdata (w_imem_word)
    );

    // Redirect beats freeze: the target is loaded and IF/ID flushed on the
    // same edge, so the target word reaches decode one edge later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc_q     <= RESET_PC;
            r_if_pc    <= '0;
            r_if_instr <= NOP;
            r_if_valid <= 1'b0;
        end else if (branch_taken) begin
            r_pc_q     <= w_branch_tgt;
            r_if_pc    <= '0;
            r_if_instr <= NOP;
            r_if_valid <= 1'b0;
        end else if (!freeze) begin
            r_pc_q     <= w_pc_seq;
            r_if_pc    <= w_pc_seq;
            r_if_instr <= w_imem_word;
            r_if_valid <= 1'b1;
        end
    end

    assign PC          = r_if_pc;
    assign Instruction = r_if_instr;
    assign valid       = r_if_valid;

`ifdef FETCH_STATS_EN
    logic [WORD_W-1:0] r_fetch_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_count <= '0;
        end else if (w_load) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign fetch_count = r_fetch_count;
`else
    logic w_unused_load;
    assign w_unused_load = w_load;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;
    import arm_pkg::*;

    localparam int          DEPTH = 64;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    function automatic logic [DEPTH*32-1:0] build_image();
        logic [DEPTH*32-1:0] img;
        img = '0;
        for (int i = 0; i < DEPTH; i++) img[i*32 +: 32] = 32'hA000_0000 + 32'(i);
        return img;
    endfunction

    localparam logic [DEPTH*32-1:0] IMG = build_image();

    logic        clk = 1'b0;
    logic        reset;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] PC;
    logic [31:0] Instruction;
    logic        valid;
`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count;
`endif

    fetch_unit #(
        .IMEM_DEPTH (DEPTH),
        .RESET_PC   (RPC),
        .IMEM_INIT  (IMG)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .PC           (PC),
        .Instruction  (Instruction),
        .valid        (valid)
`ifdef FETCH_STATS_EN
        ,
        .fetch_count  (fetch_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
        logic        v;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        m_last;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    int          checks = 0;
    int          errors = 0;

    // Memory image as seen through address aliasing: word index is the byte
    // address divided by 4, modulo the depth.
    function automatic logic [31:0] mem_word(logic [31:0] a);
        return 32'hA000_0000 + 32'((a >> 2) % DEPTH);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc       = RPC;
        m_cnt      = 0;
        m_last.ins = NOP;
        m_last.pc  = 0;
        m_last.v   = 1'b0;
        m_last.cnt = 0;
    endtask

    // Drive one cycle, push the expected IF/ID contents after the edge.
    task automatic drive(input logic f, input logic b, input logic [31:0] a);
        @(negedge clk);
        freeze       = f;
        branch_taken = b;
        branch_addr  = a;
        if (b) begin
            m_last.ins = NOP;
            m_last.pc  = 0;
            m_last.v   = 1'b0;
            m_pc       = a & ~32'h3;
        end else if (!f) begin
            m_last.ins = mem_word(m_pc);
            m_last.pc  = m_pc + 32'd4;
            m_last.v   = 1'b1;
            m_pc       = m_pc + 32'd4;
            m_cnt      = m_cnt + 32'd1;
        end
        m_last.cnt = m_cnt;
        sb_q.push_back(m_last);
        @(posedge clk);
        #2;
    endtask

    // Async pulse between edges; outputs must clear before any clock edge.
    task automatic reset_pulse();
        reset = 1'b1;
        #1;
        chk("rst_instr", Instruction, NOP);
        chk("rst_pc", PC, 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
`ifdef FETCH_STATS_EN
        chk("rst_count", fetch_count, 32'h0);
`endif
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("sb_instr", Instruction, e.ins);
                chk("sb_pc", PC, e.pc);
                chk("sb_valid", 32'(valid), 32'(e.v));
`ifdef FETCH_STATS_EN
                chk("sb_count", fetch_count, e.cnt);
`endif
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : stim
        reset        = 1'b1;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = 32'h0;
        model_reset();
        #1;
        chk("por_instr", Instruction, NOP);
        chk("por_valid", 32'(valid), 32'h0);
        @(posedge clk);
        #2;
        chk("por_pc", PC, 32'h0);
        reset = 1'b0;

        // Sequential fetch and stall
        drive(0, 0, 0);
        chk("d_i0", Instruction, 32'hA000_0000);
        chk("d_pc0", PC, 32'd4);
        drive(0, 0, 0);
        chk("d_i1", Instruction, 32'hA000_0001);
        chk("d_pc1", PC, 32'd8);
        drive(1, 0, 0);
        drive(1, 0, 0);
        chk("frz_i", Instruction, 32'hA000_0001);
        chk("frz_pc", PC, 32'd8);
        chk("frz_v", 32'(valid), 32'h1);
        drive(0, 0, 0);
        chk("d_i2", Instruction, 32'hA000_0002);
        chk("d_pc2", PC, 32'd12);

        // Redirect, redirect with freeze, aliasing
        drive(0, 1, 32'h0000_0022);
        chk("br_flush_i", Instruction, NOP);
        chk("br_flush_v", 32'(valid), 32'h0);
        drive(0, 0, 0);
        chk("br_tgt_i", Instruction, 32'hA000_0008);
        chk("br_tgt_pc", PC, 32'd36);
        drive(1, 1, 32'h0000_0022);
        chk("brf_flush_i", Instruction, NOP);
        chk("brf_flush_v", 32'(valid), 32'h0);
        drive(0, 0, 0);
        chk("brf_tgt_i", Instruction, 32'hA000_0008);
        chk("brf_tgt_pc", PC, 32'd36);
        drive(0, 1, 32'h0000_0100);
        drive(0, 0, 0);
        chk("alias_i", Instruction, 32'hA000_0000);
        chk("alias_pc", PC, 32'h0000_0104);

        // PC wrap at the top of the address space
        drive(0, 1, 32'hFFFF_FFFE);
        drive(0, 0, 0);
        chk("wrap_i", Instruction, 32'hA000_003F);
        chk("wrap_pc", PC, 32'h0);
        drive(0, 0, 0);
        chk("wrap2_i", Instruction, 32'hA000_0000);

        // Reset mid-run, then counted fetches
        reset_pulse();
        for (int i = 0; i < 5; i++) drive(0, 0, 0);
        chk("post_rst_i", Instruction, 32'hA000_0004);
`ifdef FETCH_STATS_EN
        chk("cnt5", fetch_count, 32'd5);
`endif

        // Reset during a freeze and right after a redirect
        drive(1, 0, 0);
        reset_pulse();
        drive(0, 0, 0);
        chk("rst_frz_i", Instruction, 32'hA000_0000);
        drive(0, 1, 32'h0000_0040);
        reset_pulse();
        drive(0, 0, 0);
        chk("rst_br_i", Instruction, 32'hA000_0000);

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            int unsigned r;
            logic [31:0] a;
            r = $urandom_range(0, 99);
            a = $urandom;
            if (r < 3) a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            drive(($urandom_range(0, 3) == 0), (r < 12), a);
            if (n % 97 == 96) reset_pulse();
        end

        chk("sb_drain", 32'(sb_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter IMEM_DEPTH, default 64, SHALL be the number of 32-bit words in the instruction memory, a power of two.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 freeze  input  1  SHALL be the hazard stall request; it holds the PC and the IF/ID register.
REQ-006 branch_taken  input  1  SHALL be the redirect request from the execute stage.
REQ-007 branch_addr  input  32  SHALL be the redirect target byte address.
REQ-008 PC  output  32  SHALL be the registered address+4 of the instruction on Instruction.
REQ-009 Instruction  output  32  SHALL be the registered instruction word presented to the decode stage.
REQ-010 valid  output  1  SHALL be high when Instruction holds a fetched instruction rather than a reset or flush NOP.
REQ-011 fetch_count  output  32  SHALL be the count of instructions delivered (present only per REQ-027).

Function
REQ-012 pc_q SHALL update by priority: branch_taken -> {branch_addr[31:2],2'b00}; else freeze -> hold; else pc_q+4.
REQ-013 pc_q+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-014 The memory word index SHALL be pc_q[log2(IMEM_DEPTH)+1:2]; higher address bits are ignored, so addresses alias modulo IMEM_DEPTH*4.
REQ-015 The memory read SHALL be combinational, so a word addressed in cycle n SHALL appear on Instruction after edge n+1 (one-cycle fetch latency).
REQ-016 The IF/ID register SHALL update by priority: branch_taken -> {Instruction=NOP, PC=0, valid=0}; else freeze -> hold all three; else {mem word, pc_q+4, 1}.
REQ-017 Simultaneous branch_taken and freeze SHALL behave as branch_taken alone, with redirect and flush in the same edge.
REQ-018 After a redirect, the target instruction SHALL appear on Instruction exactly one edge after the flush edge.
REQ-019 freeze held for N cycles SHALL keep PC, Instruction and valid constant for N edges, with no instruction skipped or duplicated.

Reset
REQ-020 On reset assertion, pc_q SHALL become RESET_PC immediately, independent of clk.
REQ-021 On reset assertion, Instruction SHALL become NOP, PC SHALL become 0 and valid SHALL become 0.
REQ-022 On reset assertion, fetch_count, when present, SHALL become 0.
REQ-023 Reset asserted mid-freeze or mid-redirect SHALL discard the pending operation.
REQ-024 On the first edge after reset deasserts, the unit SHALL load the word at RESET_PC with valid=1.
REQ-025 The memory contents SHALL NOT be affected by reset.

Configuration
REQ-026 Macro FETCH_STATS_EN SHALL gate the fetch_count port and counter logic.
REQ-027 With FETCH_STATS_EN defined, fetch_count SHALL increment by 1 on every edge that loads valid=1, and SHALL wrap at 2^32.
REQ-028 Without FETCH_STATS_EN, fetch_count and its counter SHALL be absent from the port list and the logic.

Structure
REQ-029 Shared package arm_pkg SHALL hold the NOP constant (32'hE1A0_0000, MOV r0,r0), the word width of 32 and the PC increment of 4.
REQ-030 The instruction memory SHALL be sub-module inst_mem, parameterized by IMEM_DEPTH and initialised from a hex image.
REQ-031 The PC register and the IF/ID register SHALL reside in fetch_unit.

Verification
REQ-032 Reset, then 3 free edges, memory word i = 32'hA000_000i -> Instruction = A0000000, A0000001, A0000002; PC = 4, 8, 12; valid = 1.
REQ-033 freeze high for 2 edges while Instruction = A0000001 -> Instruction and PC hold; next free edge gives A0000002, PC = 12.
REQ-034 branch_taken with branch_addr = 32'h0000_0022 -> next edge gives Instruction = NOP, valid = 0; the following edge gives word 8, PC = 36.
REQ-035 branch_taken and freeze asserted together -> result identical to REQ-034.
REQ-036 IMEM_DEPTH = 64, branch to 32'h0000_0100 -> Instruction = word 0 (alias), PC = 32'h0000_0104.
REQ-037 Reset pulse asserted between edges mid-run -> outputs = NOP/0/0 before the next edge; with FETCH_STATS_EN, fetch_count = 0, then 5 free edges give fetch_count = 5.
